// File: rtl/qsfp_clk_reset_sequencer_pkg.sv
// Shared definitions for the QSFP clock/reset sequencer.
// State encodings, synchroniser depth and counter sizing helpers.
package qsfp_clk_reset_sequencer_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      M_CLKGEN_RST,
      M_SETTLE,
      M_WAIT_LOCK,
      M_RUN
   } main_state_e;

   typedef enum logic [1:0] {
      C_ABSENT,
      C_DEBOUNCE,
      C_MOD_RST,
      C_ACTIVE
   } cage_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One spare bit so the terminal value never wraps.
   function automatic int cnt_width(input int max_cycles);
      return $clog2(max_cycles) + 1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/qsfp_clk_reset_sequencer_cage.sv
// Per-cage module FSM: presence debounce, module reset, activation.
// QSFP_SEQ_INT_MON_EN adds a sticky interrupt flag per cage.
module qsfp_cage_ctrl
   import qsfp_clk_reset_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MOD_RST_CYCLES  = 128
) (
   input  logic cfgmclk_int,
   input  logic reset,
   input  logic modprsl_i,
   input  logic seq_ready_i,
`ifdef QSFP_SEQ_INT_MON_EN
   input  logic intl_i,
   output logic int_sticky_o,
`endif
   output logic resetl_o,
   output logic lpmode_o,
   output logic mod_ready_o
);

   localparam int CW = cnt_width(max2(DEBOUNCE_CYCLES, MOD_RST_CYCLES));
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] MR_LAST = CW'(MOD_RST_CYCLES - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   cage_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic          resetl_q;
   logic          lpmode_q;
   logic          mod_ready_q;

   // Cage FSM; a removed module wins over every other transition.
   always_ff @(posedge cfgmclk_int) begin
      if (!reset) begin
         state_q     <= C_ABSENT;
         cnt_q       <= '0;
         resetl_q    <= 1'b0;
         lpmode_q    <= 1'b1;
         mod_ready_q <= 1'b0;
      end else if (modprsl_i) begin
         state_q     <= C_ABSENT;
         cnt_q       <= '0;
         resetl_q    <= 1'b0;
         lpmode_q    <= 1'b1;
         mod_ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            C_ABSENT: begin
               state_q <= C_DEBOUNCE;
               cnt_q   <= '0;
            end
            C_DEBOUNCE: begin
               if (cnt_q == DB_LAST) begin
                  state_q <= C_MOD_RST;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            C_MOD_RST: begin
               if (cnt_q != MR_LAST) begin
                  cnt_q <= cnt_q + ONE;
               end else if (seq_ready_i) begin
                  state_q     <= C_ACTIVE;
                  cnt_q       <= '0;
                  resetl_q    <= 1'b1;
                  lpmode_q    <= 1'b0;
                  mod_ready_q <= 1'b1;
               end
            end
            C_ACTIVE: begin
               if (!seq_ready_i) begin
                  state_q     <= C_MOD_RST;
                  cnt_q       <= '0;
                  resetl_q    <= 1'b0;
                  lpmode_q    <= 1'b1;
                  mod_ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= C_ABSENT;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign resetl_o    = resetl_q;
   assign lpmode_o    = lpmode_q;
   assign mod_ready_o = mod_ready_q;

`ifdef QSFP_SEQ_INT_MON_EN
   logic intl_prev_q;
   logic int_sticky_q;

   // Latch a falling interrupt edge only while the cage is in service.
   always_ff @(posedge cfgmclk_int) begin
      if (!reset) begin
         intl_prev_q  <= 1'b1;
         int_sticky_q <= 1'b0;
      end else begin
         intl_prev_q <= intl_i;
         if (modprsl_i || state_q != C_ACTIVE) begin
            int_sticky_q <= 1'b0;
         end else if (intl_prev_q && !intl_i) begin
            int_sticky_q <= 1'b1;
         end
      end
   end

   assign int_sticky_o = int_sticky_q;
`endif

endmodule

// File: rtl/sync_signal.sv
// Multi-stage flop synchroniser for asynchronous level inputs.
// No reset: the chain flushes within STAGES cycles.
module sync_signal #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] out_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   // Shift the input through the synchroniser chain.
   always_ff @(posedge clk_i) begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
   end

   assign out_o = sync_q[STAGES-1];

endmodule

// File: rtl/qsfp_clk_reset_sequencer.sv
// Power-up/recovery sequencer for QSFP28 clock generator, MMCM and cages.
// Define QSFP_SEQ_INT_MON_EN to add per-cage interrupt monitoring.
module qsfp_clk_reset_sequencer
   import qsfp_clk_reset_sequencer_pkg::*;
#(
   parameter int QSFP_CNT          = 2,
   parameter int CLKGEN_RST_CYCLES = 1024,
   parameter int SETTLE_CYCLES     = 1024,
   parameter int LOCK_TIMEOUT      = 65536,
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int MOD_RST_CYCLES    = 128
) (
   input  logic                cfgmclk_int,
   input  logic                reset,
   input  logic                mmcm_locked,
   input  logic [QSFP_CNT-1:0] gtpowergood,
   input  logic [QSFP_CNT-1:0] qsfp_modprsl,
   input  logic                force_reseq,
`ifdef QSFP_SEQ_INT_MON_EN
   input  logic [QSFP_CNT-1:0] qsfp_intl,
   output logic [QSFP_CNT-1:0] int_sticky,
`endif
   output logic                qsfp_refclk_reset,
   output logic                mmcm_rst,
   output logic [QSFP_CNT-1:0] qsfp_resetl,
   output logic [QSFP_CNT-1:0] qsfp_lpmode,
   output logic                seq_ready,
   output logic [QSFP_CNT-1:0] mod_ready,
   output logic [7:0]          retry_count
);

   localparam int MAXC = max2(max2(CLKGEN_RST_CYCLES, SETTLE_CYCLES),
                              max2(LOCK_TIMEOUT,
                                   max2(DEBOUNCE_CYCLES, MOD_RST_CYCLES)));
   localparam int CW = cnt_width(MAXC);
   localparam logic [CW-1:0] CG_LAST = CW'(CLKGEN_RST_CYCLES - 1);
   localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   logic                locked_s;
   logic [QSFP_CNT-1:0] pgood_s;
   logic [QSFP_CNT-1:0] modprsl_s;
   logic                ok_s;

   sync_signal #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_lock (
      .clk_i (cfgmclk_int),
      .in_i  (mmcm_locked),
      .out_o (locked_s)
   );

   sync_signal #(.WIDTH(QSFP_CNT), .STAGES(SYNC_STAGES)) u_sync_pg (
      .clk_i (cfgmclk_int),
      .in_i  (gtpowergood),
      .out_o (pgood_s)
   );

   sync_signal #(.WIDTH(QSFP_CNT), .STAGES(SYNC_STAGES)) u_sync_prs (
      .clk_i (cfgmclk_int),
      .in_i  (qsfp_modprsl),
      .out_o (modprsl_s)
   );

   assign ok_s = locked_s & (&pgood_s);

   main_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic          ok_q;
   logic          refclk_rst_q;
   logic          mmcm_rst_q;
   logic          seq_ready_q;
   logic [7:0]    retry_q;

   // Main sequencer: clkgen reset, settle, lock wait, run with recovery.
   always_ff @(posedge cfgmclk_int) begin
      if (!reset) begin
         state_q      <= M_CLKGEN_RST;
         cnt_q        <= '0;
         ok_q         <= 1'b0;
         refclk_rst_q <= 1'b1;
         mmcm_rst_q   <= 1'b1;
         seq_ready_q  <= 1'b0;
         retry_q      <= 8'd0;
      end else begin
         ok_q <= ok_s;
         unique case (state_q)
            M_CLKGEN_RST: begin
               if (cnt_q == CG_LAST) begin
                  state_q      <= M_SETTLE;
                  cnt_q        <= '0;
                  refclk_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            M_SETTLE: begin
               if (cnt_q == ST_LAST) begin
                  state_q    <= M_WAIT_LOCK;
                  cnt_q      <= '0;
                  mmcm_rst_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            M_WAIT_LOCK: begin
               if (ok_s && ok_q) begin
                  state_q <= M_RUN;
                  cnt_q   <= '0;
               end else if (cnt_q == LT_LAST) begin
                  state_q      <= M_CLKGEN_RST;
                  cnt_q        <= '0;
                  refclk_rst_q <= 1'b1;
                  mmcm_rst_q   <= 1'b1;
                  retry_q      <= sat_inc8(retry_q);
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            M_RUN: begin
               if (force_reseq) begin
                  state_q      <= M_CLKGEN_RST;
                  cnt_q        <= '0;
                  refclk_rst_q <= 1'b1;
                  mmcm_rst_q   <= 1'b1;
                  seq_ready_q  <= 1'b0;
                  if (!locked_s) begin
                     retry_q <= sat_inc8(retry_q);
                  end
               end else if (!locked_s) begin
                  state_q     <= M_SETTLE;
                  cnt_q       <= '0;
                  mmcm_rst_q  <= 1'b1;
                  seq_ready_q <= 1'b0;
                  retry_q     <= sat_inc8(retry_q);
               end else begin
                  seq_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= M_CLKGEN_RST;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign qsfp_refclk_reset = refclk_rst_q;
   assign mmcm_rst          = mmcm_rst_q;
   assign seq_ready         = seq_ready_q;
   assign retry_count       = retry_q;

`ifdef QSFP_SEQ_INT_MON_EN
   logic [QSFP_CNT-1:0] intl_s;

   sync_signal #(.WIDTH(QSFP_CNT), .STAGES(SYNC_STAGES)) u_sync_int (
      .clk_i (cfgmclk_int),
      .in_i  (qsfp_intl),
      .out_o (intl_s)
   );
`endif

   for (genvar g = 0; g < QSFP_CNT; g++) begin : g_cage
      qsfp_cage_ctrl #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .MOD_RST_CYCLES  (MOD_RST_CYCLES)
      ) u_cage (
         .cfgmclk_int  (cfgmclk_int),
         .reset        (reset),
         .modprsl_i    (modprsl_s[g]),
         .seq_ready_i  (seq_ready_q),
`ifdef QSFP_SEQ_INT_MON_EN
         .intl_i       (intl_s[g]),
         .int_sticky_o (int_sticky[g]),
`endif
         .resetl_o     (qsfp_resetl[g]),
         .lpmode_o     (qsfp_lpmode[g]),
         .mod_ready_o  (mod_ready[g])
      );
   end

endmodule

// File: doc/qsfp_clk_reset_sequencer.md
Name: qsfp_clk_reset_sequencer

Overview:
Power-up and recovery sequencer for the QSFP28 clocking and module-management path.
- Drives, in order: clock-generator (SI5335) reset, MMCM reset, and per-cage QSFP module reset/low-power control.
- Monitors MMCM lock and GT power-good. Retries on lock timeout or lock loss. Re-sequences a cage on module insertion or removal.
- Sits in the top level on the free-running configuration clock and replaces the ad-hoc reset timer logic.

Parameters:
- QSFP_CNT, 2, number of QSFP cages.
- CLKGEN_RST_CYCLES, 1024, cycles qsfp_refclk_reset is held high.
- SETTLE_CYCLES, 1024, cycles after clkgen release before mmcm_rst is released.
- LOCK_TIMEOUT, 65536, cycles to wait for mmcm_locked and all gtpowergood before retry.
- DEBOUNCE_CYCLES, 50000, cycles qsfp_modprsl must be stable low before a module is accepted.
- MOD_RST_CYCLES, 128, cycles qsfp_resetl is held low after acceptance.

Ports:
- cfgmclk_int  in  1  free-running config clock, about 50 MHz.
- reset  in  1  synchronous, active-low reset.
- mmcm_locked  in  1  MMCM lock; asynchronous to cfgmclk_int.
- gtpowergood  in  QSFP_CNT  per-quad GT power good; asynchronous.
- qsfp_modprsl  in  QSFP_CNT  module present, active low; asynchronous.
- force_reseq  in  1  single-cycle request to restart the full sequence.
- qsfp_refclk_reset  out  1  clock-generator reset, active high.
- mmcm_rst  out  1  MMCM reset, active high.
- qsfp_resetl  out  QSFP_CNT  module reset, active low.
- qsfp_lpmode  out  QSFP_CNT  module low-power mode.
- seq_ready  out  1  clocks stable.
- mod_ready  out  QSFP_CNT  cage active.
- retry_count  out  8  saturating retry counter.

Behaviour:
- Reset (reset=0 at a clock edge) has top priority and takes effect on that edge, including mid-sequence.
  - Reset values: qsfp_refclk_reset=1, mmcm_rst=1, qsfp_resetl=0, qsfp_lpmode=all 1, seq_ready=0, mod_ready=0, retry_count=0.
  - FSM enters CLKGEN_RST with its counter at 0.
- Input synchronisation: every asynchronous input passes a 2-FF synchroniser. The FSM sees an input change 2 cycles later.
- Main FSM states:
  - CLKGEN_RST: refclk_reset=1, mmcm_rst=1. After CLKGEN_RST_CYCLES cycles -> SETTLE.
  - SETTLE: refclk_reset=0, mmcm_rst=1. After SETTLE_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK: mmcm_rst=0.
    - -> RUN once synced mmcm_locked and all synced gtpowergood have been 1 for 2 consecutive cycles.
    - If the counter reaches LOCK_TIMEOUT first -> CLKGEN_RST and retry_count increments.
  - RUN: seq_ready=1 (registered, asserted the cycle after entry).
    - Synced lock loss -> SETTLE (MMCM-only retry, mmcm_rst=1) and retry_count increments.
    - force_reseq -> CLKGEN_RST, no retry increment.
    - force_reseq and lock loss in the same cycle: force_reseq wins, retry_count still increments once.
  - force_reseq is ignored in every state other than RUN.
- Counters: clear on every state entry. Width is clog2 of the largest cycle parameter plus 1. No wrap: a counter holds at its terminal value.
- retry_count saturates at 255.
- Per-cage FSM (QSFP_CNT instances):
  - ABSENT: resetl=0, lpmode=1. Synced modprsl=0 -> DEBOUNCE.
  - DEBOUNCE: any modprsl=1 -> ABSENT. Stable DEBOUNCE_CYCLES cycles -> MOD_RST.
  - MOD_RST: resetl=0. After MOD_RST_CYCLES cycles, if seq_ready=1 -> ACTIVE; otherwise hold in MOD_RST with the counter saturated.
  - ACTIVE: resetl=1, lpmode=0, mod_ready=1.
  - From any state: modprsl=1 -> ABSENT in the next cycle, outputs return to ABSENT values.
  - In ACTIVE, seq_ready falling -> MOD_RST with the counter restarted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro QSFP_SEQ_INT_MON_EN.
- With the macro: adds input qsfp_intl[QSFP_CNT] (synced) and output int_sticky[QSFP_CNT].
  - int_sticky sets on a synced falling edge of qsfp_intl while the cage is ACTIVE.
  - It clears on reset or when the cage leaves ACTIVE.
- Without the macro: neither port exists and no logic is generated.

Decomposition:
- Shared header qsfp_seq_defs.vh holds:
  - main and cage FSM state-encoding localparams;
  - the clog2-based counter-width function;
  - the synchroniser stage count (2).
- One natural sub-module, qsfp_cage_ctrl: per-cage FSM, debounce and reset counter. Instantiated QSFP_CNT times in a generate loop.
- Synchronisers reuse the existing sync_signal module.

Test Plan:
All cases use CLKGEN_RST_CYCLES=16, SETTLE_CYCLES=8, LOCK_TIMEOUT=64, DEBOUNCE_CYCLES=10, MOD_RST_CYCLES=4.
- Power-up, locked=1 and gtpowergood=2'b11 from t=0:
  - refclk_reset falls at cycle 16 after reset release and mmcm_rst falls at cycle 24;
  - seq_ready rises within 2+2+1 cycles after WAIT_LOCK entry;
  - retry_count=0.
- locked held 0: refclk_reset re-asserts after 64 cycles in WAIT_LOCK; after 3 timeouts retry_count=3; with locked=1 thereafter the sequence completes.
- locked drops for 5 cycles in RUN: seq_ready=0, mmcm_rst=1 for 8 cycles, refclk_reset stays 0, retry_count increments, ACTIVE cages drop to MOD_RST.
- Cage 0 modprsl goes 0 with a glitch to 1 at debounce cycle 5: cage returns to ABSENT. Then stable 0: resetl rises 10+4+sync cycles later, lpmode=0, mod_ready[0]=1; cage 1 stays unaffected.
- force_reseq asserted together with a lock drop in RUN: FSM enters CLKGEN_RST and retry_count increments by exactly 1. reset=0 asserted mid-SETTLE: all outputs return to reset values on the next edge.
- Module removed while ACTIVE: resetl=0, lpmode=1, mod_ready=0 within 3 cycles. With QSFP_SEQ_INT_MON_EN, an intl falling edge sets int_sticky and removal clears it.
